// File: rtl/sweep_pkg.sv
// Shared encodings for the bounce-sweep sequencer: FSM states and count direction.
package sweep_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    UP   = 2'd1,
    DOWN = 2'd2
  } sweep_state_e;

  localparam logic DIR_UP   = 1'b0;
  localparam logic DIR_DOWN = 1'b1;

endpackage

// File: rtl/sweep_ctrl_updn_core.sv
// W-bit up/down count register; load wins over a count step.
module updn_core
  import sweep_pkg::*;
#(
  parameter int unsigned W = 3
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         load,
  input  logic [W-1:0] load_val,
  input  logic         en,
  input  logic         dir,
  output logic [W-1:0] cnt
);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt <= '0;
    end else if (load) begin
      cnt <= load_val;
    end else if (en) begin
      cnt <= (dir == DIR_DOWN) ? cnt - W'(1) : cnt + W'(1);
    end
  end

endmodule

// File: rtl/sweep_ctrl.sv
// Bounce-sweep sequencer: latches bounds on start, drives updn_core lo->hi->lo for N trips.
module sweep_ctrl
  import sweep_pkg::*;
#(
  parameter int unsigned W  = 3,
  parameter int unsigned SW = 8
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          start,
  input  logic          stop,
  input  logic [W-1:0]  lo,
  input  logic [W-1:0]  hi,
  input  logic [SW-1:0] sweeps,
  output logic [W-1:0]  cnt,
  output logic          dir,
  output logic          busy,
  output logic          done,
  output logic          err
);

  sweep_state_e  state_q;
  logic [W-1:0]  lo_q;
  logic [W-1:0]  hi_q;
  logic [SW-1:0] sweeps_q;
  logic [SW-1:0] sweep_cnt_q;

  logic          accept;
  logic          last_trip;
  logic          core_load;
  logic [W-1:0]  core_load_val;
  logic          core_en;
  logic          core_dir;

  assign accept    = start && !stop && (lo < hi);
  // sweeps_q == 0 means run until stop, so it never completes.
  assign last_trip = (sweeps_q != '0) && ((sweep_cnt_q + SW'(1)) == sweeps_q);

  always_comb begin
    core_load     = 1'b0;
    core_load_val = lo_q;
    core_en       = 1'b0;
    core_dir      = DIR_UP;
    case (state_q)
      IDLE: begin
        if (accept) begin
          core_load     = 1'b1;
          core_load_val = lo;
        end
      end
      UP: begin
        if (!stop) begin
          core_en  = 1'b1;
          core_dir = (cnt == hi_q) ? DIR_DOWN : DIR_UP;
        end
      end
      DOWN: begin
        if (!stop) begin
          if (cnt != lo_q) begin
            core_en  = 1'b1;
            core_dir = DIR_DOWN;
          end else if (!last_trip) begin
            // lo is shown only once per turn, so the next trip restarts at lo+1.
            core_load     = 1'b1;
            core_load_val = lo_q + W'(1);
          end
        end
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= IDLE;
      lo_q        <= '0;
      hi_q        <= '0;
      sweeps_q    <= '0;
      sweep_cnt_q <= '0;
      dir         <= DIR_UP;
      busy        <= 1'b0;
      done        <= 1'b0;
      err         <= 1'b0;
    end else begin
      done <= 1'b0;
      err  <= 1'b0;
      case (state_q)
        IDLE: begin
          if (start && !stop) begin
            if (lo >= hi) begin
              err <= 1'b1;
            end else begin
              lo_q        <= lo;
              hi_q        <= hi;
              sweeps_q    <= sweeps;
              sweep_cnt_q <= '0;
              state_q     <= UP;
              busy        <= 1'b1;
              dir         <= DIR_UP;
            end
          end
        end
        UP: begin
          if (stop) begin
            state_q <= IDLE;
            busy    <= 1'b0;
            dir     <= DIR_UP;
          end else if (cnt == hi_q) begin
            state_q <= DOWN;
            dir     <= DIR_DOWN;
          end
        end
        DOWN: begin
          if (stop) begin
            state_q <= IDLE;
            busy    <= 1'b0;
            dir     <= DIR_UP;
          end else if (cnt == lo_q) begin
            if (last_trip) begin
              state_q <= IDLE;
              busy    <= 1'b0;
              done    <= 1'b1;
              dir     <= DIR_UP;
            end else begin
              sweep_cnt_q <= sweep_cnt_q + SW'(1);
              state_q     <= UP;
              dir         <= DIR_UP;
            end
          end
        end
        default: begin
          state_q <= IDLE;
          busy    <= 1'b0;
          dir     <= DIR_UP;
        end
      endcase
    end
  end

  updn_core #(
    .W(W)
  ) u_core (
    .clk      (clk),
    .rst      (rst),
    .load     (core_load),
    .load_val (core_load_val),
    .en       (core_en),
    .dir      (core_dir),
    .cnt      (cnt)
  );

endmodule
